montgomery_host_sequencer: RTL and testbench

//  Host-side initiator for the montgomery core command protocol (port1 cmd, bram_din, bram_dout, port2 done).
//  On start, issues READ_A(0), READ_B(1), READ_M(2), MULTIPLY(3) and WRITE(4) in order.

---
 rtl/montgomery_pkg.sv | 32 +++
 rtl/montgomery_host_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_montgomery_host_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_pkg.sv
// Shared constants and types for the montgomery host sequencer.
package montgomery_pkg;

  localparam int unsigned WORD_W    = 512;
  localparam int unsigned CMD_W     = 32;
  localparam int unsigned CMD_IDX_W = 3;

  localparam logic [CMD_IDX_W-1:0] CMD_READ_A   = 3'd0;
  localparam logic [CMD_IDX_W-1:0] CMD_READ_B   = 3'd1;
  localparam logic [CMD_IDX_W-1:0] CMD_READ_M   = 3'd2;
  localparam logic [CMD_IDX_W-1:0] CMD_MULTIPLY = 3'd3;
  localparam logic [CMD_IDX_W-1:0] CMD_WRITE    = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CMD   = 4'd1,
    S_DATA  = 4'd2,
    S_WDONE = 4'd3,
    S_RES   = 4'd4,
    S_ACK   = 4'd5,
    S_DRAIN = 4'd6,
    S_FIN   = 4'd7,
    S_ERR   = 4'd8
  } state_e;

  // Operand pair driven toward the two core BRAM ports.
  typedef struct packed {
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
  } word_pair_t;

endpackage

// File: rtl/montgomery_host_sequencer.sv
// Host-side initiator: walks the READ_A/READ_B/READ_M/MULTIPLY/WRITE command
// sequence against a montgomery core, feeding operands and capturing results.
module montgomery_host_sequencer
  import montgomery_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_load,
  input  logic [WORD_W-1:0] a1,
  input  logic [WORD_W-1:0] a2,
  input  logic [WORD_W-1:0] b1,
  input  logic [WORD_W-1:0] b2,
  input  logic [WORD_W-1:0] m1,
  input  logic [WORD_W-1:0] m2,
  output logic [WORD_W-1:0] result1,
  output logic [WORD_W-1:0] result2,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [CMD_W-1:0]  port1_dout,
  output logic              port1_valid,
  input  logic              port1_read,
  output logic [WORD_W-1:0] bram_din1,
  output logic [WORD_W-1:0] bram_din2,
  output logic              bram_din_valid,
  input  logic [WORD_W-1:0] bram_dout1,
  input  logic [WORD_W-1:0] bram_dout2,
  input  logic              bram_dout1_valid,
  input  logic              bram_dout2_valid,
  output logic              bram_dout_read,
  input  logic              port2_valid,
  output logic              port2_read
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CMD_IDX_W-1:0]   cmd_idx_q, cmd_idx_d;
  logic                   res_cap_q, res_cap_d;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   timeout_c;
  logic                   counting_c;
  logic                   capture_c;
  word_pair_t             operand_c;

  // Timeout fires on the last allowed cycle of a waiting state.
  assign timeout_c  = (to_cnt_q == TO_LAST);
  assign counting_c = (state_q == S_CMD)   || (state_q == S_DATA) ||
                      (state_q == S_WDONE) || (state_q == S_RES)  ||
                      (state_q == S_DRAIN);

  // State, command index and result-phase flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_idx_q <= CMD_READ_A;
      res_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      res_cap_q <= res_cap_d;
    end
  end

  // Next-state logic; RES is split into capture and done phases by res_cap.
  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    res_cap_d = res_cap_q;
    capture_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_idx_d = skip_load ? CMD_MULTIPLY : CMD_READ_A;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_idx_q > CMD_WRITE) begin
          state_d = S_ERR;
        end else if (port1_read) begin
          if (cmd_idx_q == CMD_MULTIPLY) begin
            state_d = S_WDONE;
          end else if (cmd_idx_q == CMD_WRITE) begin
            state_d   = S_RES;
            res_cap_d = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_DATA, S_WDONE: begin
        if (port2_valid) begin
          state_d = S_ACK;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_RES: begin
        if (!res_cap_q) begin
          if (bram_dout1_valid && bram_dout2_valid) begin
            capture_c = 1'b1;
            res_cap_d = 1'b1;
          end else if (timeout_c) begin
            state_d = S_ERR;
          end
        end else if (port2_valid) begin
          state_d = S_ACK;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!port2_valid) begin
          cmd_idx_d = cmd_idx_q + CMD_IDX_W'(1);
          state_d   = (cmd_idx_q == CMD_WRITE) ? S_FIN : S_CMD;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // Operand pair selected by the command being issued.
  always_comb begin
    operand_c = '0;
    case (cmd_idx_d)
      CMD_READ_A: begin
        operand_c.w1 = a1;
        operand_c.w2 = a2;
      end
      CMD_READ_B: begin
        operand_c.w1 = b1;
        operand_c.w2 = b2;
      end
      CMD_READ_M: begin
        operand_c.w1 = m1;
        operand_c.w2 = m2;
      end
      default: begin
        operand_c = '0;
      end
    endcase
  end

  // Handshake timeout counter, cleared on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_d != state_q) begin
      to_cnt_q <= '0;
    end else if (counting_c) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port1_dout     <= '0;
      port1_valid    <= 1'b0;
      bram_din1      <= '0;
      bram_din2      <= '0;
      bram_din_valid <= 1'b0;
      bram_dout_read <= 1'b0;
      port2_read     <= 1'b0;
      result1        <= '0;
      result2        <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      port1_valid    <= (state_d == S_CMD);
      port1_dout     <= (state_d == S_CMD) ? CMD_W'(cmd_idx_d) : '0;
      bram_din_valid <= (state_d == S_DATA);
      bram_din1      <= (state_d == S_DATA) ? operand_c.w1 : '0;
      bram_din2      <= (state_d == S_DATA) ? operand_c.w2 : '0;
      bram_dout_read <= capture_c;
      port2_read     <= (state_d == S_ACK);
      done           <= (state_d == S_FIN);
      busy           <= (state_d != S_IDLE);
      if (capture_c) begin
        result1 <= bram_dout1;
        result2 <= bram_dout2;
      end
      if ((state_q == S_IDLE) && start) begin
        error <= 1'b0;
      end else if (state_d == S_ERR) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_montgomery_host_sequencer.sv
// Bench for montgomery_host_sequencer: a bench-side core responder plus a
// per-cycle checker of the command/operand/ack protocol.
module tb_montgomery_host_sequencer;
  import montgomery_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, skip_load, start_t;
  logic [511:0] a1, a2, b1, b2, m1, m2;
  logic [511:0] result1, result2, bram_din1, bram_din2, bram_dout1, bram_dout2;
  logic [31:0]  port1_dout;
  logic done, error, busy, port1_valid, port1_read, bram_din_valid;
  logic bram_dout1_valid, bram_dout2_valid, bram_dout_read, port2_valid, port2_read;

  logic [511:0] r1_t, r2_t, din1_t, din2_t;
  logic [31:0]  p1d_t;
  logic done_t, err_t, busy_t, p1v_t, dinv_t, dread_t, p2r_t;

  montgomery_host_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .skip_load(skip_load),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .m1(m1), .m2(m2),
    .result1(result1), .result2(result2), .done(done), .error(error), .busy(busy),
    .port1_dout(port1_dout), .port1_valid(port1_valid), .port1_read(port1_read),
    .bram_din1(bram_din1), .bram_din2(bram_din2), .bram_din_valid(bram_din_valid),
    .bram_dout1(bram_dout1), .bram_dout2(bram_dout2),
    .bram_dout1_valid(bram_dout1_valid), .bram_dout2_valid(bram_dout2_valid),
    .bram_dout_read(bram_dout_read), .port2_valid(port2_valid), .port2_read(port2_read)
  );

  montgomery_host_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(5)) u_to (
    .clk(clk), .reset(reset), .start(start_t), .skip_load(1'b0),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .m1(m1), .m2(m2),
    .result1(r1_t), .result2(r2_t), .done(done_t), .error(err_t), .busy(busy_t),
    .port1_dout(p1d_t), .port1_valid(p1v_t), .port1_read(1'b0),
    .bram_din1(din1_t), .bram_din2(din2_t), .bram_din_valid(dinv_t),
    .bram_dout1('0), .bram_dout2('0),
    .bram_dout1_valid(1'b0), .bram_dout2_valid(1'b0),
    .bram_dout_read(dread_t), .port2_valid(1'b0), .port2_read(p2r_t)
  );

  int n_chk = 0;
  int n_fail = 0;
  // Protocol model state: expected command list and observed event counts.
  int exp_cmd[$];
  int pos, acks, dones, reads, dinv;
  logic [511:0] op1 [3];
  logic [511:0] op2 [3];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit main_zero();
    return ~|{result1, result2, done, error, busy, port1_dout, port1_valid,
              bram_din1, bram_din2, bram_din_valid, bram_dout_read, port2_read};
  endfunction

  task automatic set_ops();
    a1 = rand512(); a2 = rand512(); b1 = rand512();
    b2 = rand512(); m1 = rand512(); m2 = rand512();
    op1[0] = a1; op2[0] = a2; op1[1] = b1; op2[1] = b2; op1[2] = m1; op2[2] = m2;
  endtask

  // Per-cycle check of the main instance's outputs against the command model.
  task automatic cycle_check();
    int c;
    if (reset || (start && !busy)) begin
      pos = 0; acks = 0; dones = 0; reads = 0; dinv = 0;
      return;
    end
    if (port1_valid) begin
      if (pos < exp_cmd.size()) chk("p1_dout", 512'(port1_dout), 512'(exp_cmd[pos]));
      else chki("p1_extra_cmd", pos, exp_cmd.size() - 1);
      if (port1_read) pos++;
    end
    if (bram_din_valid) begin
      dinv++;
      c = (pos > 0) ? exp_cmd[pos-1] : -1;
      if (c >= 0 && c < 3) begin
        chk("din1", bram_din1, op1[c]);
        chk("din2", bram_din2, op2[c]);
      end else begin
        chki("din_cmd", c, 0);
      end
    end
    if (port2_read) acks++;
    if (done) dones++;
    if (bram_dout_read) reads++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  // Core responder for one command.
  task automatic serve(input int p1_dly, input int p2_dly, input int p2_extra,
                       input bit early, input bit poke,
                       input logic [511:0] r1, input logic [511:0] r2);
    int n;
    logic [31:0] cmd;
    bit stable;
    n = 0;
    while (!port1_valid && n < 200) begin tick(); n++; end
    chki("p1_valid_seen", int'(port1_valid), 1);
    if (!port1_valid) return;
    cmd = port1_dout;
    stable = 1'b1;
    for (int i = 0; i < p1_dly; i++) begin
      if (poke && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
      if (!port1_valid || port1_dout != cmd) stable = 1'b0;
    end
    chki("p1_stable", int'(stable), 1);
    port1_read = 1'b1;
    tick();
    port1_read = 1'b0;
    chki("p1_drop", int'(port1_valid), 0);
    if (cmd == 32'd4) begin
      if (early) begin
        port2_valid = 1'b1;
        tick();
        port2_valid = 1'b0;
      end
      repeat (p2_dly) tick();
      bram_dout1 = r1; bram_dout2 = r2;
      bram_dout1_valid = 1'b1; bram_dout2_valid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!bram_dout_read && n < 200);
      chki("dout_read", int'(bram_dout_read), 1);
      bram_dout1_valid = 1'b0; bram_dout2_valid = 1'b0;
    end else begin
      repeat (p2_dly) tick();
    end
    port2_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!port2_read && n < 200);
    chki("p2_read", int'(port2_read), 1);
    repeat (p2_extra) tick();
    port2_valid = 1'b0;
  endtask

  // Full sequence: start, serve each expected command, check the outcome.
  task automatic do_run(input bit skip, input int p1_fix, input int extra_fix,
                        input bit early, input bit poke,
                        input logic [511:0] r1, input logic [511:0] r2);
    int n;
    exp_cmd.delete();
    for (int c = (skip ? 3 : 0); c < 5; c++) exp_cmd.push_back(c);
    skip_load = skip; start = 1'b1;
    tick();
    start = 1'b0; skip_load = 1'b0;
    for (int k = 0; k < exp_cmd.size(); k++)
      serve((p1_fix >= 0) ? p1_fix : int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            (extra_fix >= 0) ? extra_fix : int'($urandom_range(0, 3)),
            early, poke && ($urandom_range(0, 1) == 1), r1, r2);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chki("done_seen", int'(done), 1);
    tick();
    chki("done_pulse", int'(done), 0);
    chki("busy_idle", int'(busy), 0);
    chki("done_count", dones, 1);
    chki("cmds_issued", pos, exp_cmd.size());
    chki("acks", acks, exp_cmd.size());
    chki("dout_reads", reads, 1);
    chki("error_clear", int'(error), 0);
    chki("din_used", int'(dinv > 0), int'(!skip));
    chk("result1", result1, r1);
    chk("result2", result2, r2);
  endtask

  initial begin
    int n;
    logic [511:0] dead;
    reset = 1'b1; start = 1'b0; skip_load = 1'b0; start_t = 1'b0;
    port1_read = 1'b0; port2_valid = 1'b0;
    bram_dout1 = '0; bram_dout2 = '0; bram_dout1_valid = 1'b0; bram_dout2_valid = 1'b0;
    set_ops();
    repeat (3) tick();
    chki("rst_zero", int'(main_zero()), 1);
    chki("rst_zero_t", int'(~|{done_t, err_t, busy_t, p1v_t, p1d_t, dinv_t, dread_t, p2r_t}), 1);
    reset = 1'b0;
    tick();

    // T1: full run, core returns DEADBEEF in the top word.
    dead = 512'hDEADBEEF;
    dead = dead << 480;
    do_run(1'b0, -1, -1, 1'b0, 1'b0, dead, rand512());
    chk("t1_result1_lit", result1, {32'hDEADBEEF, 480'd0});
    chki("t1_cmds_lit", pos, 5);

    // T2: operands already loaded.
    set_ops();
    do_run(1'b1, -1, -1, 1'b0, 1'b0, rand512(), rand512());
    chki("t2_cmds_lit", pos, 2);
    chki("t2_no_din_lit", dinv, 0);

    // T3: 100-cycle command acceptance delay.
    set_ops();
    do_run(1'b0, 100, 0, 1'b0, 1'b0, rand512(), rand512());

    // T4: done held for 3 cycles on every command.
    set_ops();
    do_run(1'b0, -1, 2, 1'b0, 1'b0, rand512(), rand512());
    chki("t4_acks_lit", acks, 5);

    // Randomised runs with spurious starts and early done pulses.
    for (int r = 0; r < 6; r++) begin
      set_ops();
      do_run(1'($urandom_range(0, 1)), -1, -1, 1'($urandom_range(0, 1)), 1'b1,
             rand512(), rand512());
    end

    // T6: reset while an operand is being presented.
    set_ops();
    exp_cmd.delete();
    for (int c = 0; c < 5; c++) exp_cmd.push_back(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!port1_valid && n < 50) begin tick(); n++; end
    port1_read = 1'b1;
    tick();
    port1_read = 1'b0;
    chki("t6_in_data", int'(bram_din_valid), 1);
    reset = 1'b1;
    tick();
    chki("t6_rst_zero", int'(main_zero()), 1);
    reset = 1'b0;
    tick();
    set_ops();
    do_run(1'b0, -1, -1, 1'b0, 1'b0, rand512(), rand512());

    // T5: 16-cycle timeout on a core that never accepts commands.
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    chki("t5_p1_valid", int'(p1v_t), 1);
    chki("t5_p1_dout", int'(p1d_t), 0);
    n = 0;
    while (!err_t && n < 100) begin tick(); n++; end
    chki("t5_to_cycles", n, 16);
    chki("t5_valid_drop", int'(p1v_t), 0);
    chki("t5_busy_err", int'(busy_t), 1);
    tick();
    chki("t5_busy_idle", int'(busy_t), 0);
    chki("t5_err_sticky", int'(err_t), 1);
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    chki("t5_err_cleared", int'(err_t), 0);
    chki("t5_busy_again", int'(busy_t), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
